// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared types for the LED blink bank.
// Mode encoding and the reset-time half-period helper.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    // Half-period that gives a 1 Hz blink at the board clock.
    function automatic int unsigned default_half(
        input int unsigned clk_hz
    );
        return clk_hz / 2;
    endfunction

endpackage

// File: rtl/led_blink_bank_if.sv
// led_blink_bank_if: channel programming port of the blink bank.
// wr_en/wr_ch/wr_mode/wr_half write one channel, sync_all realigns blinkers.
interface led_blink_bank_if
    import led_blink_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = 26
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    mode_t            wr_mode;
    logic [CNT_W-1:0] wr_half;
    logic             sync_all;

    modport master (
        output wr_en, wr_ch, wr_mode, wr_half, sync_all
    );

    modport slave (
        input wr_en, wr_ch, wr_mode, wr_half, sync_all
    );

endinterface

// File: rtl/led_blink_bank_channel.sv
// blink_channel: one LED channel with mode/half/count state.
// In: CLOCK_50, reset, wr_stb, wr_mode, wr_half, sync_all. Out: led, done.
module blink_channel
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 26
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             wr_stb,
    input  mode_t            wr_mode,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             sync_all,
    output logic             led,
    output logic             done
);

    localparam logic [CNT_W-1:0] DEF_HALF =
        CNT_W'(default_half(CLK_HZ));

    mode_t            mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] count;
    logic             term;

    // Terminal count: the last cycle of the current level.
    assign term = (count == half - 1'b1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode  <= MODE_OFF;
            half  <= DEF_HALF;
            count <= '0;
            led   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_stb) begin
                mode  <= wr_mode;
                half  <= (wr_half == '0) ? CNT_W'(1) : wr_half;
                count <= '0;
                led   <= (wr_mode != MODE_OFF);
            end else if (sync_all && mode == MODE_BLINK) begin
                count <= '0;
                led   <= 1'b1;
            end else begin
                unique case (mode)
                    MODE_BLINK: begin
                        if (term) begin
                            led   <= ~led;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        if (term) begin
                            led   <= 1'b0;
                            mode  <= MODE_OFF;
                            count <= '0;
                            done  <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    MODE_ON: begin
                        count <= '0;
                        led   <= 1'b1;
                    end
                    MODE_OFF: begin
                        count <= '0;
                        led   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/led_blink_bank.sv
// led_blink_bank: N_CH independent blink channels driving LEDG.
// In: CLOCK_50, reset, wr (slave port). Out: LEDG, oneshot_done.
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int N_CH   = 8,
    parameter int CNT_W  = 26
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    led_blink_bank_if.slave     wr,
    output logic [N_CH-1:0]     LEDG,
    output logic [N_CH-1:0]     oneshot_done
);

    logic [N_CH-1:0] wr_stb;

    // Index values with no matching channel decode to no strobe.
    always_comb begin
        wr_stb = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_stb[i] = wr.wr_en && (int'(wr.wr_ch) == i);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        blink_channel #(
            .CLK_HZ (CLK_HZ),
            .CNT_W  (CNT_W)
        ) u_ch (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .wr_stb   (wr_stb[i]),
            .wr_mode  (wr.wr_mode),
            .wr_half  (wr.wr_half),
            .sync_all (wr.sync_all),
            .led      (LEDG[i]),
            .done     (oneshot_done[i])
        );
    end

endmodule
